fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage placed directly upstream of the instruction memory. Owns the PC,
//   drives pc_out to the memory's ReadAddress (combinational word read, index = addr/4),
//   and registers the returned word plus PC into the IF/ID pipeline register for decode.
//   Handles stall, branch/jump redirect with flush, end-of-program halt and misaligned-target error.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC value loaded on reset
//   IMEM_WORDS  10             instruction memory depth in words; valid PC range is 0 .. IMEM_WORDS*4-4
//   NOP_INSTR   32'h0000_0013  bubble word written to ifid_instr on flush or halt (addi x0,x0,0)
// PORTS
//   clock            in   1   single clock, all state on posedge
//   reset            in   1   synchronous, active-high
//   stall            in   1   hold PC and IF/ID contents (hazard from decode)
//   redirect_valid   in   1   taken branch/jump from a later stage
//   redirect_target  in   32  new PC when redirect_valid=1
//   instr_in         in   32  word returned by instruction memory for pc_out (same cycle)
//   pc_out           out  32  current PC; connects to memory ReadAddress
//   ifid_instr       out  32  registered instruction
//   ifid_pc          out  32  PC of ifid_instr
//   ifid_pc_plus4    out  32  ifid_pc + 4
//   ifid_valid       out  1   ifid_* holds a real instruction
//   halted           out  1   fetch stopped: PC ran past IMEM_WORDS*4-4
//   fetch_err        out  1   sticky: redirect to target with target[1:0]!=0
// BEHAVIOUR
//   - Reset (sync, wins over everything): pc_out=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=0,
//     ifid_pc_plus4=0, ifid_valid=0, halted=0, fetch_err=0, state=RUN.
//   - FSM states: RUN, HALT, ERR. Event priority per edge: reset > redirect > stall > advance.
//   - RUN, advance (no stall/redirect): ifid_instr<=instr_in, ifid_pc<=pc_out,
//     ifid_pc_plus4<=pc_out+4, ifid_valid<=1, pc_out<=pc_out+4. Latency PC->IF/ID = 1 cycle.
//   - RUN, stall=1, no redirect: pc_out and all ifid_* hold their values.
//   - Redirect (RUN or HALT, with or without stall): pc_out<=redirect_target; IF/ID flushed
//     (ifid_instr<=NOP_INSTR, ifid_valid<=0, ifid_pc/ifid_pc_plus4 hold).
//     Target aligned: next state RUN (halted<=0). Target misaligned: pc_out holds, state ERR, fetch_err<=1.
//   - End of program: in RUN, when advancing from pc_out==IMEM_WORDS*4-4, that last word is
//     latched normally, then pc_out holds, state HALT, halted<=1 on that same edge.
//     pc_out at or above IMEM_WORDS*4 (e.g. by redirect) -> no latch, flush, HALT.
//   - HALT: pc_out holds; each edge writes ifid_valid<=0, ifid_instr<=NOP_INSTR; stall ignored;
//     only redirect or reset exits.
//   - ERR: terminal until reset; pc_out holds, ifid_valid=0, redirect and stall ignored.
//   - Arithmetic: 32-bit unsigned, PC+4 wraps modulo 2^32 (unreachable while IMEM_WORDS limit holds).
//   - pc_out is a register output, never combinational from inputs; instr_in sampled only on advance.
// CONFIGURATION
//   FETCH_PERF_COUNTERS_EN defined: adds ports perf_fetched (out 32; +1 per edge that writes
//     ifid_valid<=1) and perf_bubbles (out 32; +1 per edge in RUN/HALT that leaves ifid_valid=0
//     or holds under stall). Both are 0 on reset and saturate at 32'hFFFF_FFFF.
//   Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//   1 Reset then 3 free-run edges, memory words W0..W2 -> ifid_instr=W0,W1,W2;
//     ifid_pc=0,4,8; ifid_valid=1 from edge 1; pc_out=12.
//   2 stall=1 for 2 edges at pc_out=8 -> pc_out stays 8, ifid_pc stays 4; release -> ifid_pc=8.
//   3 redirect_valid=1, target=0x10, with stall=1 -> pc_out=0x10, ifid_valid=0, ifid_instr=0x13;
//     next edge ifid_pc=0x10, ifid_valid=1.
//   4 Run to pc_out=36 (IMEM_WORDS=10) -> word 9 latched, halted=1, pc_out holds 36;
//     then redirect target=0 -> halted=0, fetch restarts from 0.
//   5 Redirect target=0x6 -> fetch_err=1, ifid_valid=0 forever; later redirect ignored; reset clears.
//   6 Reset asserted mid-run with stall=1 and redirect_valid=1 -> all outputs at reset values next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fronts the instruction memory and fills the IF/ID register.
// Optional build macro FETCH_PERF_COUNTERS_EN adds perf_fetched / perf_bubbles counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 10,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        halted,
    output logic        fetch_err,
`ifdef FETCH_PERF_COUNTERS_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles,
`endif
    output logic [1:0]  state
);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_HALT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);
    localparam logic [31:0] PC_LAST  = PC_LIMIT - 32'd4;

    // Handshake: no valid/ready here; instr_in is trusted only on an advancing edge in RUN,
    // and the IF/ID consumer qualifies ifid_* with ifid_valid.
    logic        do_latch;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_out + 32'd4;
    assign do_latch = (state == S_RUN) && !redirect_valid && !stall && (pc_out < PC_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_RUN;
            pc_out        <= RESET_PC;
            ifid_instr    <= NOP_INSTR;
            ifid_pc       <= 32'd0;
            ifid_pc_plus4 <= 32'd0;
            ifid_valid    <= 1'b0;
            halted        <= 1'b0;
            fetch_err     <= 1'b0;
        end else if (state != S_ERR) begin
            if (redirect_valid) begin
                ifid_instr <= NOP_INSTR;
                ifid_valid <= 1'b0;
                if (redirect_target[1:0] == 2'b00) begin
                    pc_out <= redirect_target;
                    state  <= S_RUN;
                    halted <= 1'b0;
                end else begin
                    state     <= S_ERR;
                    fetch_err <= 1'b1;
                end
            end else if (state == S_HALT) begin
                ifid_instr <= NOP_INSTR;
                ifid_valid <= 1'b0;
            end else if (!stall) begin
                if (pc_out >= PC_LIMIT) begin
                    // Redirected past the end of memory: nothing valid to fetch.
                    ifid_instr <= NOP_INSTR;
                    ifid_valid <= 1'b0;
                    state      <= S_HALT;
                    halted     <= 1'b1;
                end else begin
                    ifid_instr    <= instr_in;
                    ifid_pc       <= pc_out;
                    ifid_pc_plus4 <= pc_plus4;
                    ifid_valid    <= 1'b1;
                    if (pc_out == PC_LAST) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        pc_out <= pc_plus4;
                    end
                end
            end
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_bubbles <= 32'd0;
        end else if (state != S_ERR) begin
            if (do_latch) begin
                if (perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
            end else begin
                if (perf_bubbles != 32'hFFFF_FFFF) perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: table of per-edge vectors plus hand-written reset/out-of-range sequences.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset, stall, redirect_valid;
    logic [31:0] redirect_target, instr_in;
    logic [31:0] pc_out, ifid_instr, ifid_pc, ifid_pc_plus4;
    logic        ifid_valid, halted, fetch_err;
    logic [1:0]  state;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Clock and memory model
    always #5 clock = ~clock;

    logic [31:0] imem [10];
    always_comb begin
        instr_in = 32'hDEAD_BEEF;
        if (pc_out < 32'd40) instr_in = imem[pc_out[5:2]];
    end

    fetch_stage dut (
        .clock(clock), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .instr_in(instr_in), .pc_out(pc_out), .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid),
        .halted(halted), .fetch_err(fetch_err),
`ifdef FETCH_PERF_COUNTERS_EN
        .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles),
`endif
        .state(state)
    );

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] target;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ifpc;
        logic        valid;
        logic        halted;
        logic        err;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] ifpc, input logic [31:0] pc4, input logic valid,
                             input logic hlt, input logic err);
        check({tag, ".pc_out"}, pc_out, pc);
        check({tag, ".ifid_instr"}, ifid_instr, instr);
        check({tag, ".ifid_pc"}, ifid_pc, ifpc);
        check({tag, ".ifid_pc_plus4"}, ifid_pc_plus4, pc4);
        check({tag, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, valid});
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, hlt});
        check({tag, ".fetch_err"}, {31'd0, fetch_err}, {31'd0, err});
    endtask

    task automatic drive(input logic rst, input logic stl, input logic rv, input logic [31:0] tgt);
        reset = rst; stall = stl; redirect_valid = rv; redirect_target = tgt;
    endtask

    initial begin
        for (int i = 0; i < 10; i++) imem[i] = 32'h0A00_0000 + 32'(i);

        //          stall rv target        pc            instr          ifpc          v  h  e
        vecs[0]  = '{1'b0, 1'b0, 32'h0,  32'h04, 32'h0A00_0000, 32'h00, 1, 0, 0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,  32'h08, 32'h0A00_0001, 32'h04, 1, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,  32'h08, 32'h0A00_0001, 32'h04, 1, 0, 0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,  32'h08, 32'h0A00_0001, 32'h04, 1, 0, 0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,  32'h0C, 32'h0A00_0002, 32'h08, 1, 0, 0};
        vecs[5]  = '{1'b1, 1'b1, 32'h10, 32'h10, NOP,           32'h08, 0, 0, 0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,  32'h14, 32'h0A00_0004, 32'h10, 1, 0, 0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,  32'h18, 32'h0A00_0005, 32'h14, 1, 0, 0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,  32'h1C, 32'h0A00_0006, 32'h18, 1, 0, 0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,  32'h20, 32'h0A00_0007, 32'h1C, 1, 0, 0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,  32'h24, 32'h0A00_0008, 32'h20, 1, 0, 0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,  32'h24, 32'h0A00_0009, 32'h24, 1, 1, 0};
        vecs[12] = '{1'b0, 1'b0, 32'h0,  32'h24, NOP,           32'h24, 0, 1, 0};
        vecs[13] = '{1'b1, 1'b0, 32'h0,  32'h24, NOP,           32'h24, 0, 1, 0};
        vecs[14] = '{1'b0, 1'b1, 32'h0,  32'h00, NOP,           32'h24, 0, 0, 0};
        vecs[15] = '{1'b0, 1'b0, 32'h0,  32'h04, 32'h0A00_0000, 32'h00, 1, 0, 0};
        vecs[16] = '{1'b0, 1'b1, 32'h6,  32'h04, NOP,           32'h00, 0, 0, 1};
        vecs[17] = '{1'b0, 1'b0, 32'h0,  32'h04, NOP,           32'h00, 0, 0, 1};
        vecs[18] = '{1'b0, 1'b1, 32'h0,  32'h04, NOP,           32'h00, 0, 0, 1};
        vecs[19] = '{1'b1, 1'b0, 32'h0,  32'h04, NOP,           32'h00, 0, 0, 1};

        // Reset
        drive(1, 0, 0, 32'h0);
        step();
        step();
        check_all("reset", 32'h0, NOP, 32'h0, 32'h0, 0, 0, 0);
`ifdef FETCH_PERF_COUNTERS_EN
        check("reset.perf_fetched", perf_fetched, 32'h0);
        check("reset.perf_bubbles", perf_bubbles, 32'h0);
`endif

        // Table-driven sequence: free run, stall, redirect, end-of-program, misaligned error
        for (int i = 0; i < 20; i++) begin
            drive(0, vecs[i].stall, vecs[i].rv, vecs[i].target);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].ifpc,
                      vecs[i].ifpc + 32'd4, vecs[i].valid, vecs[i].halted, vecs[i].err);
        end

        // Reset from ERR with stall and redirect also asserted
        drive(1, 1, 1, 32'h8);
        step();
        check_all("reset_busy", 32'h0, NOP, 32'h0, 32'h0, 0, 0, 0);

        // Reset mid-run with stall and redirect
        drive(0, 0, 0, 32'h0);
        step();
        step();
        check_all("prerun", 32'h08, 32'h0A00_0001, 32'h04, 32'h08, 1, 0, 0);
        drive(1, 1, 1, 32'h10);
        step();
        check_all("reset_midrun", 32'h0, NOP, 32'h0, 32'h0, 0, 0, 0);

        // Aligned redirect beyond memory: next advance halts without latching
        drive(0, 0, 1, 32'h40);
        step();
        check_all("oor_redirect", 32'h40, NOP, 32'h0, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 32'h0);
        step();
        check_all("oor_halt", 32'h40, NOP, 32'h0, 32'h0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
